// File: rtl/out_queue.sv
// In-order output queue between issue and the UART sender. Entries hold an operand that may
// still be in flight plus its branch speculation depth, and drain as 1- or 4-byte transfers
// once non-speculative and ready.
module out_queue #(
    parameter int unsigned N_ENTRY   = 8,
    parameter int unsigned N_CDB     = 2,
    parameter int unsigned N_B_ENTRY = 4,
    parameter int unsigned TAG_W     = 6
) (
    input  logic                                clk,
    input  logic                                reset,
    // Register-file read result (only the first read port is relevant here)
    input  logic                                gpr_read_valid,
    input  logic [TAG_W-1:0]                    gpr_read_tag,
    input  logic [31:0]                         gpr_read_data,
    // Result broadcasts; lower index has priority on a (illegal) multiple hit
    input  logic [N_CDB-1:0]                    gpr_cdb_valid,
    input  logic [N_CDB-1:0][TAG_W-1:0]         gpr_cdb_tag,
    input  logic [N_CDB-1:0][31:0]              gpr_cdb_data,
    input  logic [$clog2(N_B_ENTRY):0]          b_count_next,
    input  logic                                b_commit,
    input  logic                                issue_req_valid,
    output logic                                issue_req_ready,
    input  logic                                issue_word,
    input  logic                                sender_ready,
    output logic                                sender_valid,
    output logic [7:0]                          sender_in,
    input  logic                                failure,
    output logic                                empty
);

    localparam int unsigned CNT_W = $clog2(N_ENTRY) + 1;
    localparam int unsigned BC_W  = $clog2(N_B_ENTRY) + 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       byte_idx_q, byte_idx_d;

    logic             opd_valid_q [N_ENTRY];
    logic [TAG_W-1:0] opd_tag_q   [N_ENTRY];
    logic [31:0]      opd_data_q  [N_ENTRY];
    logic             word_q      [N_ENTRY];
    logic [BC_W-1:0]  bc_q        [N_ENTRY];

    logic             opd_valid_d [N_ENTRY];
    logic [TAG_W-1:0] opd_tag_d   [N_ENTRY];
    logic [31:0]      opd_data_d  [N_ENTRY];
    logic             word_d      [N_ENTRY];
    logic [BC_W-1:0]  bc_d        [N_ENTRY];

    // Resident entries after this cycle's CDB snoop and branch commit
    logic             upd_valid [N_ENTRY];
    logic [31:0]      upd_data  [N_ENTRY];
    logic [BC_W-1:0]  upd_bc    [N_ENTRY];

    logic             new_valid;
    logic [31:0]      new_data;
    logic             xfer, pop, accept;
    logic [CNT_W-1:0] wr_slot, run_len;
    logic             run_stop;

    // Head decode: registered state only, so sender_in is stable while stalled
    always_comb begin
        sender_valid    = (count_q != '0) && (bc_q[0] == '0) && opd_valid_q[0];
        sender_in       = opd_data_q[0][{byte_idx_q, 3'b000} +: 8];
        empty           = (count_q == '0);
        xfer            = sender_valid && sender_ready;
        pop             = xfer && (!word_q[0] || byte_idx_q == 2'd3);
        issue_req_ready = !reset && (pop || count_q < CNT_W'(N_ENTRY));
        accept          = issue_req_valid && issue_req_ready && !failure;
        wr_slot         = count_q - CNT_W'(pop);
    end

    // Snoop the CDBs for resident entries and the entry being issued; walk high to low
    // so the lowest matching bus index ends up winning
    always_comb begin
        for (int i = 0; i < int'(N_ENTRY); i++) begin
            upd_valid[i] = opd_valid_q[i];
            upd_data[i]  = opd_data_q[i];
            upd_bc[i]    = (b_commit && bc_q[i] != '0) ? bc_q[i] - BC_W'(1) : bc_q[i];
            if (!opd_valid_q[i]) begin
                for (int c = int'(N_CDB) - 1; c >= 0; c--) begin
                    if (gpr_cdb_valid[c] && gpr_cdb_tag[c] == opd_tag_q[i]) begin
                        upd_valid[i] = 1'b1;
                        upd_data[i]  = gpr_cdb_data[c];
                    end
                end
            end
        end
        new_valid = gpr_read_valid;
        new_data  = gpr_read_data;
        if (!gpr_read_valid) begin
            for (int c = int'(N_CDB) - 1; c >= 0; c--) begin
                if (gpr_cdb_valid[c] && gpr_cdb_tag[c] == gpr_read_tag) begin
                    new_valid = 1'b1;
                    new_data  = gpr_cdb_data[c];
                end
            end
        end
    end

    // Length of the leading non-speculative run; this is what survives a flush
    always_comb begin
        run_len  = '0;
        run_stop = 1'b0;
        for (int i = 0; i < int'(N_ENTRY); i++) begin
            if (!run_stop && CNT_W'(i) < count_q && bc_q[i] == '0) begin
                run_len = run_len + CNT_W'(1);
            end else begin
                run_stop = 1'b1;
            end
        end
    end

    // Next-state: shift on pop, write the accepted entry behind the survivors
    always_comb begin
        for (int i = 0; i < int'(N_ENTRY); i++) begin
            int src;
            src = (pop && i != int'(N_ENTRY) - 1) ? i + 1 : i;
            opd_valid_d[i] = upd_valid[src];
            opd_tag_d[i]   = opd_tag_q[src];
            opd_data_d[i]  = upd_data[src];
            word_d[i]      = word_q[src];
            bc_d[i]        = upd_bc[src];
            if (accept && CNT_W'(i) == wr_slot) begin
                opd_valid_d[i] = new_valid;
                opd_tag_d[i]   = gpr_read_tag;
                opd_data_d[i]  = new_data;
                word_d[i]      = issue_word;
                bc_d[i]        = b_count_next;
            end
        end

        if (failure) begin
            count_d = run_len - CNT_W'(pop);
        end else begin
            count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
        end

        byte_idx_d = byte_idx_q;
        if (xfer) begin
            byte_idx_d = pop ? 2'd0 : byte_idx_q + 2'd1;
        end
        // A mid-word head is never speculative, so it only resets when nothing survives
        if (failure && count_d == '0) begin
            byte_idx_d = 2'd0;
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            byte_idx_q <= 2'd0;
        end else begin
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    // Entry payloads need no reset; count gates their validity
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(N_ENTRY); i++) begin
            opd_valid_q[i] <= opd_valid_d[i];
            opd_tag_q[i]   <= opd_tag_d[i];
            opd_data_q[i]  <= opd_data_d[i];
            word_q[i]      <= word_d[i];
            bc_q[i]        <= bc_d[i];
        end
    end

endmodule

// File: tb/tb_out_queue.sv
// Scoreboard bench for out_queue: stimulus pushes expected bytes, a negedge monitor pops and
// compares every byte transfer and checks hold stability during stalls.
module tb_out_queue;

    localparam int unsigned N_ENTRY   = 8;
    localparam int unsigned N_CDB     = 2;
    localparam int unsigned N_B_ENTRY = 4;
    localparam int unsigned TAG_W     = 6;

    logic                        clk;
    logic                        reset;
    logic                        gpr_read_valid;
    logic [TAG_W-1:0]            gpr_read_tag;
    logic [31:0]                 gpr_read_data;
    logic [N_CDB-1:0]            cdb_valid;
    logic [N_CDB-1:0][TAG_W-1:0] cdb_tag;
    logic [N_CDB-1:0][31:0]      cdb_data;
    logic [2:0]                  b_count_next;
    logic                        b_commit;
    logic                        issue_valid;
    logic                        issue_ready;
    logic                        issue_word;
    logic                        sender_ready;
    logic                        sender_valid;
    logic [7:0]                  sender_in;
    logic                        failure;
    logic                        empty;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    out_queue #(
        .N_ENTRY  (N_ENTRY),
        .N_CDB    (N_CDB),
        .N_B_ENTRY(N_B_ENTRY),
        .TAG_W    (TAG_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .gpr_read_valid (gpr_read_valid),
        .gpr_read_tag   (gpr_read_tag),
        .gpr_read_data  (gpr_read_data),
        .gpr_cdb_valid  (cdb_valid),
        .gpr_cdb_tag    (cdb_tag),
        .gpr_cdb_data   (cdb_data),
        .b_count_next   (b_count_next),
        .b_commit       (b_commit),
        .issue_req_valid(issue_valid),
        .issue_req_ready(issue_ready),
        .issue_word     (issue_word),
        .sender_ready   (sender_ready),
        .sender_valid   (sender_valid),
        .sender_in      (sender_in),
        .failure        (failure),
        .empty          (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on every transfer, hold check across stalls
    logic       stall_prev = 1'b0;
    logic [7:0] held_byte  = 8'h00;
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && sender_valid === 1'b1) begin
                chk("hold_stable", {24'h0, sender_in}, {24'h0, held_byte});
            end
            if (sender_valid === 1'b1 && sender_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no transfer", sender_in);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (sender_in !== e) begin
                        errors++;
                        $display("FAIL byte_order: got 0x%0h, expected 0x%0h", sender_in, e);
                    end
                end
            end
            stall_prev = (sender_valid === 1'b1) && !sender_ready;
            held_byte  = sender_in;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_issue();
        issue_valid    = 1'b0;
        gpr_read_valid = 1'b0;
        issue_word     = 1'b0;
        b_count_next   = 3'd0;
    endtask

    task automatic do_issue(input logic v, input logic [TAG_W-1:0] tag, input logic [31:0] data,
                            input logic word, input logic [2:0] bc);
        issue_valid    = 1'b1;
        gpr_read_valid = v;
        gpr_read_tag   = tag;
        gpr_read_data  = data;
        issue_word     = word;
        b_count_next   = bc;
        step();
        clear_issue();
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d bytes pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset          = 1'b1;
        gpr_read_tag   = '0;
        gpr_read_data  = '0;
        cdb_valid      = '0;
        cdb_tag        = '0;
        cdb_data       = '0;
        b_commit       = 1'b0;
        sender_ready   = 1'b0;
        failure        = 1'b0;
        clear_issue();

        // Reset outputs
        step();
        step();
        chk("rst_sender_valid", {31'h0, sender_valid}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_ready", {31'h0, issue_ready}, 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {31'h0, issue_ready}, 32'h1);

        // Single byte, sendable the cycle after issue
        sender_ready = 1'b1;
        exp_q.push_back(8'h41);
        do_issue(1'b1, '0, 32'h41, 1'b0, 3'd0);
        chk("byte_valid", {31'h0, sender_valid}, 32'h1);
        chk("byte_data", {24'h0, sender_in}, 32'h41);
        step();
        chk("byte_empty_after", {31'h0, empty}, 32'h1);

        // Word with a two-cycle stall in the middle
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        do_issue(1'b1, '0, 32'h44332211, 1'b1, 3'd0);
        step();
        chk("word_byte1", {24'h0, sender_in}, 32'h22);
        sender_ready = 1'b0;
        step();
        step();
        chk("word_stall_data", {24'h0, sender_in}, 32'h22);
        sender_ready = 1'b1;
        step();
        step();
        chk("word_last_byte", {24'h0, sender_in}, 32'h44);
        chk("word_not_popped", {31'h0, empty}, 32'h0);
        step();
        chk("word_popped", {31'h0, empty}, 32'h1);
        chk("word_all_sent", exp_q.size(), 32'd0);

        // Fill with operands waiting on tags 10..17, wake them in reverse order on CDB1
        for (int i = 0; i < int'(N_ENTRY); i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
            do_issue(1'b0, TAG_W'(10 + i), 32'h0, 1'b0, 3'd0);
        end
        chk("full_ready_low", {31'h0, issue_ready}, 32'h0);
        issue_valid    = 1'b1;
        gpr_read_valid = 1'b1;
        gpr_read_data  = 32'hEE;
        for (int k = int'(N_ENTRY) - 1; k >= 0; k--) begin
            cdb_valid[1] = 1'b1;
            cdb_tag[1]   = TAG_W'(10 + k);
            cdb_data[1]  = 32'hA0 + 32'(k);
            #1;
            chk("full_ready_while_blocked", {31'h0, issue_ready}, 32'h0);
            step();
        end
        cdb_valid = '0;
        chk("full_ready_on_pop", {31'h0, issue_ready}, 32'h1);
        gpr_read_data = 32'hB8;
        exp_q.push_back(8'hB8);
        step();
        clear_issue();
        wait_drain(40);
        chk("full_drained_empty", {31'h0, empty}, 32'h1);

        // Commit releases a speculative entry one cycle later
        exp_q.push_back(8'h33);
        do_issue(1'b1, '0, 32'h33, 1'b0, 3'd1);
        chk("spec_blocked", {31'h0, sender_valid}, 32'h0);
        b_commit = 1'b1;
        step();
        b_commit = 1'b0;
        chk("commit_releases", {31'h0, sender_valid}, 32'h1);
        wait_drain(10);

        // Flush while the head word is on byte 2
        sender_ready = 1'b0;
        exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        exp_q.push_back(8'h03); exp_q.push_back(8'h04);
        exp_q.push_back(8'h55);
        do_issue(1'b1, '0, 32'h04030201, 1'b1, 3'd0);
        do_issue(1'b1, '0, 32'h55, 1'b0, 3'd0);
        do_issue(1'b1, '0, 32'h66, 1'b0, 3'd1);
        do_issue(1'b1, '0, 32'h77, 1'b0, 3'd2);
        sender_ready = 1'b1;
        step();
        step();
        chk("flush_head_byte2", {24'h0, sender_in}, 32'h03);
        failure        = 1'b1;
        issue_valid    = 1'b1;
        gpr_read_valid = 1'b1;
        gpr_read_data  = 32'h99;
        step();
        failure = 1'b0;
        clear_issue();
        chk("flush_continues_byte3", {24'h0, sender_in}, 32'h04);
        wait_drain(20);
        chk("flush_survivors_only", {31'h0, empty}, 32'h1);

        // Same-cycle CDB capture at issue
        exp_q.push_back(8'h5A);
        cdb_valid[0] = 1'b1;
        cdb_tag[0]   = TAG_W'(5);
        cdb_data[0]  = 32'h5A;
        do_issue(1'b0, TAG_W'(5), 32'h0, 1'b0, 3'd0);
        cdb_valid = '0;
        chk("capture_valid", {31'h0, sender_valid}, 32'h1);
        chk("capture_data", {24'h0, sender_in}, 32'h5A);
        wait_drain(10);

        // Reset mid-word with three entries queued
        sender_ready = 1'b0;
        exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
        do_issue(1'b1, '0, 32'hDDCCBBAA, 1'b1, 3'd0);
        do_issue(1'b1, '0, 32'h11, 1'b0, 3'd0);
        do_issue(1'b1, '0, 32'h12, 1'b0, 3'd0);
        sender_ready = 1'b1;
        step();
        step();
        chk("pre_reset_sent", exp_q.size(), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("after_reset_empty", {31'h0, empty}, 32'h1);
        chk("after_reset_valid", {31'h0, sender_valid}, 32'h0);
        exp_q.push_back(8'h21); exp_q.push_back(8'h43);
        exp_q.push_back(8'h65); exp_q.push_back(8'h87);
        do_issue(1'b1, '0, 32'h87654321, 1'b1, 3'd0);
        chk("after_reset_byte0", {24'h0, sender_in}, 32'h21);
        wait_drain(20);
        repeat (3) step();
        chk("final_empty", {31'h0, empty}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/out_queue.md
# out_queue

In-order output queue between issue and the UART sender. Each `out` instruction becomes an entry holding its source operand, which may still be in flight, and its branch speculation depth. Entries drain to the sender as 1-byte or 4-byte (little-endian, byte-serialised) transfers, and only after they become non-speculative. This is the parametrised successor of the single-byte, fixed-depth output buffer: it adds a configurable depth, several CDBs, word mode, same-cycle CDB capture at issue, and a synchronous reset.

## Interface
- `N_ENTRY`, default 8: queue depth; any value ≥2, not restricted to powers of two.
- `N_CDB`, default 2: number of GPR result buses snooped.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `gpr_read` input `cdb_t[2]`: register-file read result. Only `[0]` is used: `valid`, `tag`, `data[31:0]`.
- `gpr_cdb` input `cdb_t[N_CDB]`: result broadcasts. A hit is defined by `tag_match()` from `common.vh`.
- `b_count_next` input `$clog2(N_B_ENTRY)+1`: speculation depth of the instruction being issued, already net of this cycle's branch commit.
- `b_commit` input 1: the oldest unresolved branch committed this cycle.
- `issue_req` `req_if`: `valid` in, `ready` out.
- `issue_word` input 1: with `issue_req.valid`, 1 = send 4 bytes, 0 = send the low byte.
- `sender_ready` input 1; `sender_valid` output 1; `sender_in` output 8: byte stream to the UART sender.
- `failure` input 1: branch misprediction flush.
- `empty` output 1: `count==0`, used by the halt/drain logic.

## Operation
- State:
  - `count` (`$clog2(N_ENTRY)+1` bits).
  - Entries `e[0..N_ENTRY-1]`, each holding `{opd.valid, opd.tag, opd.data[31:0], word, b_count}`; `e[0]` is the head.
  - `byte_idx[1:0]`: next byte of the head to send.
- New entry contents:
  - `opd` comes from `gpr_read[0]`.
  - If `gpr_read[0]` is not valid but some CDB matches its tag in the same cycle, the entry is written valid with that CDB's data.
  - `b_count` = `b_count_next`; `word` = `issue_word`.
- Every cycle, each resident entry is updated:
  - If its operand is invalid and any CDB matches its tag, it becomes valid with that data. If several CDBs match, the lowest index wins; more than one match is illegal.
  - `b_count` decrements when `b_commit` is high and `b_count != 0`. It saturates at 0.
- Sending:
  - `sender_valid = count!=0 && e[0].b_count==0 && e[0].opd.valid`.
  - `sender_in = e[0].opd.data[8*byte_idx +: 8]`.
  - A transfer happens when `sender_valid && sender_ready`.
  - On a transfer, if `!e[0].word || byte_idx==3`, pop the head: entries shift down by one with updated contents, and `byte_idx` returns to 0. Otherwise `byte_idx` increments.
- Issue:
  - `issue_req.ready = !reset && (pop || count<N_ENTRY)`.
  - An accepted entry is written at slot `count - pop`.
- Failure:
  - `count` becomes (length of the leading run of entries with `b_count==0`) − `pop`. Issue in that cycle is discarded.
  - A mid-word head is always non-speculative, because `b_count` never increases. It therefore survives, and `byte_idx` is kept (or advanced) as normal.
  - If the surviving count is 0, `byte_idx` returns to 0.
- Reset:
  - Sets `count=0` and `byte_idx=0`. Entry payloads are don't-care.
  - Reset dominates `failure`, issue and send in the same cycle. A word half-sent at reset is abandoned.

## Timing
- Outputs during and after reset: `sender_valid=0`, `empty=1`, `issue_req.ready=0` during reset and 1 on the first cycle after.
- `sender_valid`, `sender_in` and `empty` are decoded only from registers. `issue_req.ready` depends combinationally on `sender_ready` through `pop`.
- Latency:
  - An entry issued in cycle t with a ready operand and `b_count_next==0` can send in cycle t+1.
  - A CDB hit in cycle t makes the head sendable in cycle t+1.
  - A `b_commit` taking `b_count` from 1 to 0 in cycle t allows sending in cycle t+1.
- Throughput: one byte per cycle. A word entry occupies the head for at least 4 cycles.
- When full, issue and pop in the same cycle is legal: `count` stays at `N_ENTRY`.
- `sender_in` must stay stable while `sender_valid && !sender_ready`.

## Test plan
- Reset, then issue byte entry `0x41` (ready, `b_count_next=0`) with `sender_ready=1` → `sender_in=0x41` in the following cycle; `empty=1` afterwards.
- Issue word `0x44332211`, stall `sender_ready` for 2 cycles midway → bytes `11,22,33,44` in order, each held stable while stalled; pop happens only after `0x44`.
- Fill `N_ENTRY` entries whose operands wait on tags T0..T7, then broadcast them in reverse order on CDB1 → `ready` is low while full; output order equals issue order; the next issue is accepted in the same cycle as the first pop.
- Entries with `b_count` = 0,0,1,2; assert `failure` while the head is sending byte 2 of a word → `count=2`, `byte_idx` continues at 3, and no bytes from the speculative entries appear.
- Issue with `gpr_read` invalid while CDB0 carries the matching tag with data `0x5A` → the entry is sendable next cycle with `0x5A`.
- Assert `reset` mid-word with 3 entries queued → the next cycle has `empty=1` and `sender_valid=0`; a later issue starts at `byte_idx=0`.
